// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: request, multiplier and response bundle for mult_share_arb
// slave = arbiter side; master = requesters plus the external multiplier driving mul_out.
interface mult_share_arb_if #(parameter int bw = 16, parameter int NREQ = 4);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*bw-1:0] req_A;
  logic [NREQ*bw-1:0] req_B;
  logic [bw-1:0]      mul_A;
  logic [bw-1:0]      mul_B;
  logic [2*bw-1:0]    mul_out;
  logic [NREQ-1:0]    rsp_valid;
  logic [2*bw-1:0]    rsp_data;
  logic               busy;
  modport master (output req_valid, req_A, req_B, mul_out, input req_ready, mul_A, mul_B, rsp_valid, rsp_data, busy);
  modport slave (input req_valid, req_A, req_B, mul_out, output req_ready, mul_A, mul_B, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter sharing one external multiplier among NREQ requesters
// Ports: CLK; RESET (synchronous, active high); bus (slave modport) carrying the request
// handshake and operands, registered multiplier operands, the multiplier product, one-hot
// responses and busy. Define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mult_share_arb #(
  parameter int bw   = 16,
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input logic           CLK,
  input logic           RESET,
  mult_share_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] base, idx;
  logic hit, acc;
  logic [bw-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  // One extra stage beyond LAT accounts for the operand register in front of the multiplier.
  logic [IW:0] tag_q [LAT+1];
  logic [IW:0] tag_d [LAT+1];
  logic [LAT:0] vld;
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign base = ptr_q;
  always_comb ptr_d = RESET ? '0 : acc ? (idx == IW'(NREQ-1) ? '0 : idx + 1'b1) : ptr_q;
  always_ff @(posedge CLK) ptr_q <= ptr_d;
`endif
  // Scan downward from base+NREQ-1 so the last hit written is the first valid index from base.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (bus.req_valid[(int'(base) + k) % NREQ]) begin
        hit = 1'b1;
        idx = IW'((int'(base) + k) % NREQ);
      end
  end
  assign acc = hit & ~RESET;
  always_comb begin
    mul_a_d = RESET ? '0 : acc ? bus.req_A[int'(idx)*bw +: bw] : mul_a_q;
    mul_b_d = RESET ? '0 : acc ? bus.req_B[int'(idx)*bw +: bw] : mul_b_q;
    tag_d[0] = RESET ? '0 : {acc, idx};
    for (int i = 1; i <= LAT; i++) tag_d[i] = RESET ? '0 : tag_q[i-1];
    vld = '0;
    for (int i = 0; i <= LAT; i++) vld[i] = tag_q[i][IW];
  end
  always_ff @(posedge CLK) begin
    mul_a_q <= mul_a_d;
    mul_b_q <= mul_b_d;
    for (int i = 0; i <= LAT; i++) tag_q[i] <= tag_d[i];
  end
  assign bus.req_ready = acc ? NREQ'(1) << idx : '0;
  assign bus.mul_A     = mul_a_q;
  assign bus.mul_B     = mul_b_q;
  assign bus.rsp_valid = (tag_q[LAT][IW] && !RESET) ? NREQ'(1) << tag_q[LAT][IW-1:0] : '0;
  assign bus.rsp_data  = bus.mul_out;
  assign bus.busy      = (|vld) && !RESET;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: scoreboard bench for mult_share_arb with LAT=1 and LAT=4 instances
module tb_mult_share_arb;
  localparam int BW = 16, N = 4;
  typedef struct { int idx; logic [2*BW-1:0] data; int due; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q1[$], q4[$];
  logic [2*BW-1:0] p4 [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mult_share_arb_if #(.bw(BW), .NREQ(N)) i1();
  mult_share_arb_if #(.bw(BW), .NREQ(N)) i4();
  mult_share_arb #(.bw(BW), .NREQ(N), .LAT(1)) u1 (.CLK(clk), .RESET(rst), .bus(i1));
  mult_share_arb #(.bw(BW), .NREQ(N), .LAT(4)) u4 (.CLK(clk), .RESET(rst), .bus(i4));
  always @(posedge clk) begin
    i1.mul_out <= rst ? '0 : 32'(i1.mul_A) * 32'(i1.mul_B);
    p4[0] <= rst ? '0 : 32'(i4.mul_A) * 32'(i4.mul_B);
    p4[1] <= rst ? '0 : p4[0];
    p4[2] <= rst ? '0 : p4[1];
    i4.mul_out <= rst ? '0 : p4[2];
  end
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++)
      if (i1.req_valid[i] && i1.req_ready[i])
        q1.push_back('{i, 32'(i1.req_A[i*BW +: BW]) * 32'(i1.req_B[i*BW +: BW]), cyc + 2});
    if (i1.rsp_valid != 0) begin
      n_chk++;
      if (q1.size() == 0) begin n_fail++; $display("FAIL sb1_unexpected: rsp_valid=%b data=%h, no response outstanding", i1.rsp_valid, i1.rsp_data); end
      else begin
        e = q1.pop_front();
        if (i1.rsp_valid !== 4'(1 << e.idx) || i1.rsp_data !== e.data || cyc != e.due) begin
          n_fail++; $display("FAIL sb1_rsp: got valid=%b data=%h cycle=%0d, required valid=%b data=%h cycle=%0d", i1.rsp_valid, i1.rsp_data, cyc, 4'(1 << e.idx), e.data, e.due);
        end
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      n_chk++; n_fail++; $display("FAIL sb1_missing: no response at cycle %0d, required valid=%b data=%h", cyc, 4'(1 << q1[0].idx), q1[0].data);
      void'(q1.pop_front());
    end
    for (int i = 0; i < N; i++)
      if (i4.req_valid[i] && i4.req_ready[i])
        q4.push_back('{i, 32'(i4.req_A[i*BW +: BW]) * 32'(i4.req_B[i*BW +: BW]), cyc + 5});
    if (i4.rsp_valid != 0) begin
      n_chk++;
      if (q4.size() == 0) begin n_fail++; $display("FAIL sb4_unexpected: rsp_valid=%b data=%h, no response outstanding", i4.rsp_valid, i4.rsp_data); end
      else begin
        e = q4.pop_front();
        if (i4.rsp_valid !== 4'(1 << e.idx) || i4.rsp_data !== e.data || cyc != e.due) begin
          n_fail++; $display("FAIL sb4_rsp: got valid=%b data=%h cycle=%0d, required valid=%b data=%h cycle=%0d", i4.rsp_valid, i4.rsp_data, cyc, 4'(1 << e.idx), e.data, e.due);
        end
      end
    end else if (q4.size() > 0 && q4[0].due <= cyc) begin
      n_chk++; n_fail++; $display("FAIL sb4_missing: no response at cycle %0d, required valid=%b data=%h", cyc, 4'(1 << q4[0].idx), q4[0].data);
      void'(q4.pop_front());
    end
  end
  task automatic test_reset();
    rst = 1'b1;
    i1.req_valid = '1; i1.req_A = '0; i1.req_B = '0;
    i4.req_valid = '1; i4.req_A = '0; i4.req_B = '0;
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (i1.req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready1: got %b required 0000", i1.req_ready); end
      n_chk++; if (i1.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp1: got %b required 0000", i1.rsp_valid); end
      n_chk++; if (i1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b required 0", i1.busy); end
      n_chk++; if (i1.mul_A !== 16'h0 || i1.mul_B !== 16'h0) begin n_fail++; $display("FAIL reset_mul1: got A=%h B=%h required 0/0", i1.mul_A, i1.mul_B); end
      n_chk++; if (i4.req_ready !== 4'b0 || i4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready4: got ready=%b busy=%b required 0000/0", i4.req_ready, i4.busy); end
    end
    @(posedge clk); #1;
    rst = 1'b0; i1.req_valid = '0; i4.req_valid = '0;
    @(negedge clk);
    n_chk++; if (i1.mul_A !== 16'h0 || i1.mul_B !== 16'h0 || i1.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset1: got A=%h B=%h busy=%b required 0/0/0", i1.mul_A, i1.mul_B, i1.busy); end
  endtask
`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
  task automatic test_round_robin();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin i1.req_A[i*BW +: BW] = 16'(i + 1); i1.req_B[i*BW +: BW] = 16'd10; end
    i1.req_valid = 4'b1111;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 5) begin
        n_chk++; if (i1.req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant%0d: got %b required %b", c, i1.req_ready, 4'(1 << (c % 4))); end
      end
      if (c >= 2) begin
        n_chk++; if (i1.rsp_valid !== 4'(1 << ((c - 2) % 4)) || i1.rsp_data !== 32'(((c - 2) % 4 + 1) * 10)) begin n_fail++; $display("FAIL rr_rsp%0d: got valid=%b data=%0d required valid=%b data=%0d", c, i1.rsp_valid, i1.rsp_data, 4'(1 << ((c - 2) % 4)), ((c - 2) % 4 + 1) * 10); end
      end
      @(posedge clk); #1;
      if (c == 4) i1.req_valid = '0;
    end
  endtask
`else
  task automatic test_fixed_prio();
    @(posedge clk); #1;
    i1.req_A = {16'd4, 16'd3, 16'd2, 16'd1}; i1.req_B = {4{16'd7}};
    i1.req_valid = 4'b0101;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (i1.req_ready !== 4'b0001) begin n_fail++; $display("FAIL fixed_grant%0d: got %b required 0001", c, i1.req_ready); end
      @(posedge clk); #1;
    end
    i1.req_valid = 4'b0100;
    @(negedge clk);
    n_chk++; if (i1.req_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_grant_drop: got %b required 0100", i1.req_ready); end
    @(posedge clk); #1;
    i1.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask
`endif
  task automatic test_single(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    i1.req_A[15:0] = a; i1.req_B[15:0] = b; i1.req_valid = 4'b0001;
    @(negedge clk);
    n_chk++; if (i1.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b required 0001", i1.req_ready); end
    @(posedge clk); #1;
    i1.req_valid = '0;
    @(negedge clk);
    n_chk++; if (i1.mul_A !== a || i1.mul_B !== b || i1.rsp_valid !== 4'b0) begin n_fail++; $display("FAIL single_mul: got A=%h B=%h rsp=%b required A=%h B=%h rsp=0000", i1.mul_A, i1.mul_B, i1.rsp_valid, a, b); end
    @(negedge clk);
    n_chk++; if (i1.rsp_valid !== 4'b0001 || i1.rsp_data !== 32'(a) * 32'(b)) begin n_fail++; $display("FAIL single_rsp: got valid=%b data=%h required 0001/%h", i1.rsp_valid, i1.rsp_data, 32'(a) * 32'(b)); end
  endtask
  task automatic test_reset_midflight();
    @(posedge clk); #1;
    i1.req_A[2*BW +: BW] = 16'd9; i1.req_B[2*BW +: BW] = 16'd9; i1.req_valid = 4'b0100;
    @(negedge clk);
    n_chk++; if (i1.req_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant: got %b required 0100", i1.req_ready); end
    @(posedge clk); #1;
    rst = 1'b1; i1.req_valid = '0; i4.req_valid = '0; q1.delete(); q4.delete();
    @(negedge clk);
    n_chk++; if (i1.rsp_valid !== 4'b0 || i1.busy !== 1'b0) begin n_fail++; $display("FAIL mid_in_reset: got rsp=%b busy=%b required 0000/0", i1.rsp_valid, i1.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++; if (i1.rsp_valid !== 4'b0 || i1.busy !== 1'b0) begin n_fail++; $display("FAIL mid_after%0d: got rsp=%b busy=%b required 0000/0", c, i1.rsp_valid, i1.busy); end
    end
    @(posedge clk); #1;
    i1.req_A = {16'd5, 16'd0, 16'd6, 16'd0}; i1.req_B = {16'd5, 16'd0, 16'd6, 16'd0}; i1.req_valid = 4'b1010;
    @(negedge clk);
    n_chk++; if (i1.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ptr: got %b required 0010", i1.req_ready); end
    @(posedge clk); #1;
    i1.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_pipelined();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin i4.req_A[i*BW +: BW] = 16'(i + 2); i4.req_B[i*BW +: BW] = 16'(i + 7); end
    i4.req_valid = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 3) begin
        n_chk++; if (i4.req_ready !== 4'(1 << c)) begin n_fail++; $display("FAIL pipe_grant%0d: got %b required %b", c, i4.req_ready, 4'(1 << c)); end
      end
      n_chk++; if (i4.busy !== (c >= 1 && c <= 7)) begin n_fail++; $display("FAIL pipe_busy%0d: got %b required %b", c, i4.busy, (c >= 1 && c <= 7)); end
      if (c >= 5 && c <= 7) begin
        n_chk++; if (i4.rsp_valid !== 4'(1 << (c - 5)) || i4.rsp_data !== 32'((c - 3) * (c + 2))) begin n_fail++; $display("FAIL pipe_rsp%0d: got valid=%b data=%0d required %b/%0d", c, i4.rsp_valid, i4.rsp_data, 4'(1 << (c - 5)), (c - 3) * (c + 2)); end
      end
      @(posedge clk); #1;
      i4.req_valid = (c + 1 < 3) ? 4'(1 << (c + 1)) : 4'b0;
    end
  endtask
  task automatic test_drain();
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_chk++; if (q1.size() != 0 || q4.size() != 0) begin n_fail++; $display("FAIL drain: got %0d/%0d outstanding required 0/0", q1.size(), q4.size()); end
    n_chk++; if (i1.busy !== 1'b0 || i4.busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: got %b/%b required 0/0", i1.busy, i4.busy); end
  endtask
  initial begin
    test_reset();
`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_single(16'd3, 16'd5);
    test_single(16'hFFFF, 16'hFFFF);
    test_reset_midflight();
    test_pipelined();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
